// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall-controller state encoding, default limits
// and the bundle of fetch/decode control enables the controller drives.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } stall_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int WAIT_LIMIT_DEF   = 255;
  localparam int WAIT_CNT_W       = 8;
  localparam int STALL_CNT_W      = 16;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pc_sel_branch;
    logic ifid_flush;
    logic id_bubble;
    logic pipe_freeze;
    logic halt_ack;
  } stall_ctrl_t;

  // Free-running fetch: PC and IF/ID both advance.
  function automatic stall_ctrl_t ctrl_run();
    stall_ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    return c;
  endfunction

  function automatic stall_ctrl_t ctrl_freeze();
    stall_ctrl_t c;
    c             = '0;
    c.pipe_freeze = 1'b1;
    return c;
  endfunction

  function automatic stall_ctrl_t ctrl_bubble();
    stall_ctrl_t c;
    c           = '0;
    c.id_bubble = 1'b1;
    return c;
  endfunction

  // Held in reset: nothing advances and both front stages see NOPs.
  function automatic stall_ctrl_t ctrl_reset();
    stall_ctrl_t c;
    c            = '0;
    c.ifid_flush = 1'b1;
    c.id_bubble  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: drives PC and IF/ID enables, the ID/EX
// bubble mux and the back-end freeze from hazards, memory waits and halt.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT   = WAIT_LIMIT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ld_use_haz,
  input  logic        br_ctrl,
  input  logic        br_taken,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        pc_sel_branch,
  output logic        ifid_flush,
  output logic        id_bubble,
  output logic        pipe_freeze,
  output logic        halt_ack,
  output logic        dmem_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = WAIT_CNT_W'(WAIT_LIMIT);

  stall_state_e            cur_state;
  stall_state_e            nxt_state;
  stall_state_e            ret_state;
  stall_state_e            nxt_ret;
  stall_state_e            eff_state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [WAIT_CNT_W-1:0]   nxt_wait;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic [DRAIN_W-1:0]      nxt_drain;
  logic                    timeout_q;
  logic                    nxt_timeout;
  logic                    br_hit;
  logic                    stall_en;
  logic [STALL_CNT_W-1:0]  stall_raw;
  stall_ctrl_t             ctrl;

  assign br_hit = br_ctrl & br_taken;

  // The cycle dmem_busy drops in MEM_WAIT already behaves as the saved state,
  // so the released stage does not lose a cycle.
  assign eff_state = ((cur_state == ST_MEM_WAIT) && !dmem_busy) ? ret_state : cur_state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state <= ST_RUN;
      ret_state <= ST_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      ret_state <= nxt_ret;
      wait_cnt  <= nxt_wait;
      drain_cnt <= nxt_drain;
      timeout_q <= nxt_timeout;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    nxt_ret     = ret_state;
    nxt_wait    = '0;
    nxt_drain   = drain_cnt;
    nxt_timeout = timeout_q;
    case (eff_state)
      ST_RUN: begin
        if (dmem_busy) begin
          nxt_state = ST_MEM_WAIT;
          nxt_ret   = ST_RUN;
        end else if (halt_req && !ld_use_haz) begin
          nxt_state = ST_DRAIN;
          nxt_drain = '0;
        end else begin
          nxt_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (dmem_busy) begin
          nxt_state = ST_MEM_WAIT;
          nxt_ret   = ST_DRAIN;
        end else if (drain_cnt == DRAIN_LAST) begin
          nxt_state = ST_HALTED;
          nxt_drain = '0;
        end else begin
          nxt_state = ST_DRAIN;
          nxt_drain = drain_cnt + DRAIN_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // Only reached while dmem_busy is still high; counter parks at the limit.
        nxt_state   = ST_MEM_WAIT;
        nxt_wait    = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_CNT_W'(1);
        nxt_timeout = timeout_q | (nxt_wait == WAIT_MAX);
      end
      ST_HALTED: begin
        nxt_state = halt_req ? ST_HALTED : ST_RUN;
      end
      default: begin
        nxt_state = ST_RUN;
      end
    endcase
  end

  always_comb begin
    ctrl = ctrl_run();
    if (!reset_n) begin
      ctrl = ctrl_reset();
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (dmem_busy) begin
            ctrl = ctrl_freeze();
          end else if (ld_use_haz) begin
            ctrl = ctrl_bubble();
          end else if (halt_req) begin
            // Let the ID instruction go, stop fetching unless a branch redirects.
            ctrl.pc_write      = br_hit;
            ctrl.pc_sel_branch = br_hit;
            ctrl.ifid_flush    = 1'b1;
          end else if (br_hit) begin
            ctrl.pc_sel_branch = 1'b1;
            ctrl.ifid_flush    = 1'b1;
          end else if (imem_busy) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          ctrl = dmem_busy ? ctrl_freeze() : ctrl_bubble();
        end
        ST_MEM_WAIT: begin
          ctrl = ctrl_freeze();
        end
        ST_HALTED: begin
          ctrl          = ctrl_bubble();
          ctrl.halt_ack = 1'b1;
        end
        default: begin
          ctrl = ctrl_reset();
        end
      endcase
    end
  end

  // Lost fetch cycles are only charged while the front end would otherwise run.
  assign stall_en = ((cur_state == ST_RUN) || (cur_state == ST_MEM_WAIT)) && !ctrl.pc_write;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .en    (stall_en),
    .count (stall_raw)
  );

  assign pc_write      = ctrl.pc_write;
  assign ifid_write    = ctrl.ifid_write;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign ifid_flush    = ctrl.ifid_flush;
  assign id_bubble     = ctrl.id_bubble;
  assign pipe_freeze   = ctrl.pipe_freeze;
  assign halt_ack      = ctrl.halt_ack;
  assign dmem_timeout  = reset_n & timeout_q;
  assign state         = reset_n ? cur_state : ST_RUN;
  assign stall_cnt     = reset_n ? stall_raw : '0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model of the controller.
module tb_pipe_stall_ctrl;

  localparam int WL  = 255;
  localparam int DC  = 3;
  localparam int RUN = 0;
  localparam int MW  = 1;
  localparam int DRN = 2;
  localparam int HLT = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_use_haz = 1'b0;
  logic        br_ctrl = 1'b0;
  logic        br_taken = 1'b0;
  logic        imem_busy = 1'b0;
  logic        dmem_busy = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_write, ifid_write, pc_sel_branch, ifid_flush, id_bubble;
  logic        pipe_freeze, halt_ack, dmem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int m_state = RUN;
  int m_ret   = RUN;
  int m_drain = 0;
  int m_wait  = 0;
  int m_stall = 0;
  bit m_to    = 1'b0;
  logic [25:0] exp_vec;

  pipe_stall_ctrl #(
    .WAIT_LIMIT   (WL),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ld_use_haz    (ld_use_haz),
    .br_ctrl       (br_ctrl),
    .br_taken      (br_taken),
    .imem_busy     (imem_busy),
    .dmem_busy     (dmem_busy),
    .halt_req      (halt_req),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .pc_sel_branch (pc_sel_branch),
    .ifid_flush    (ifid_flush),
    .id_bubble     (id_bubble),
    .pipe_freeze   (pipe_freeze),
    .halt_ack      (halt_ack),
    .dmem_timeout  (dmem_timeout),
    .state         (state),
    .stall_cnt     (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [25:0] dut_vec();
    return {pc_write, ifid_write, pc_sel_branch, ifid_flush, id_bubble, pipe_freeze,
            halt_ack, dmem_timeout, state, stall_cnt};
  endfunction

  // Which behaviour applies this cycle: a released memory wait acts as the saved mode.
  function automatic int phase_now();
    return (m_state == MW && !dmem_busy) ? m_ret : m_state;
  endfunction

  function automatic logic [25:0] model_out();
    bit pcw = 0, ifw = 0, sel = 0, fl = 0, bub = 0, frz = 0, ack = 0;
    bit taken;
    int ph;
    if (!reset_n) return {4'b0001, 1'b1, 21'd0};
    taken = br_ctrl && br_taken;
    ph    = phase_now();
    if (ph == HLT) begin
      bub = 1; ack = 1;
    end else if (ph == MW || dmem_busy) begin
      frz = 1;
    end else if (ph == DRN || ld_use_haz) begin
      bub = 1;
    end else begin
      ifw = 1;
      sel = taken;
      pcw = taken || (!halt_req && !imem_busy);
      fl  = taken || halt_req || imem_busy;
    end
    return {pcw, ifw, sel, fl, bub, frz, ack, m_to, 2'(m_state), 16'(m_stall)};
  endfunction

  function automatic void model_update();
    int ph;
    if (!reset_n) begin
      m_state = RUN; m_ret = RUN; m_drain = 0; m_wait = 0; m_stall = 0; m_to = 0;
      return;
    end
    if ((m_state == RUN || m_state == MW) && !exp_vec[25] && m_stall < 65535) m_stall++;
    ph = phase_now();
    if (ph == MW) begin
      if (m_wait < WL) m_wait++;
      if (m_wait >= WL) m_to = 1;
    end else begin
      m_wait = 0;
    end
    case (ph)
      RUN: begin
        if (dmem_busy) begin m_ret = RUN; m_state = MW; end
        else if (halt_req && !ld_use_haz) begin m_state = DRN; m_drain = 0; end
        else m_state = RUN;
      end
      DRN: begin
        if (dmem_busy) begin m_ret = DRN; m_state = MW; end
        else begin
          m_drain++;
          if (m_drain == DC) begin m_state = HLT; m_drain = 0; end
          else m_state = DRN;
        end
      end
      MW:      m_state = MW;
      default: m_state = halt_req ? HLT : RUN;
    endcase
  endfunction

  task automatic apply(input bit rn, input bit ld, input bit bc, input bit bt,
                       input bit im, input bit dm, input bit hr);
    @(negedge clock);
    reset_n = rn; ld_use_haz = ld; br_ctrl = bc; br_taken = bt;
    imem_busy = im; dmem_busy = dm; halt_req = hr;
    #1;
    exp_vec = model_out();
    chk("cycle_outputs", {6'd0, dut_vec()}, {6'd0, exp_vec});
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step(input bit rn, input bit ld, input bit bc, input bit bt,
                      input bit im, input bit dm, input bit hr);
    apply(rn, ld, bc, bt, im, dm, hr);
    tick();
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("rst_ctrl", 32'({pc_write, ifid_write, ifid_flush, id_bubble, pipe_freeze,
                         halt_ack, pc_sel_branch}), 32'(7'b0011000));
    tick();
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_timeout", 32'(dmem_timeout), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hr;
    do_reset();

    // Single load-use stall
    apply(1, 1, 0, 0, 0, 0, 0);
    chk("ld_ctrl", 32'({pc_write, ifid_write, id_bubble}), 32'(3'b001));
    tick();
    chk("ld_stall", 32'(stall_cnt), 32'd1);
    chk("ld_state", 32'(state), 32'd0);

    // Taken branch wins over a busy instruction memory
    apply(1, 0, 1, 1, 1, 0, 0);
    chk("br_ctrl", 32'({pc_write, pc_sel_branch, ifid_flush}), 32'(3'b111));
    tick();

    // Four-cycle data memory wait from RUN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 0, 1, 0);
      chk("dmem_freeze", 32'(pipe_freeze), 32'd1);
      chk("dmem_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    chk("dmem_release", 32'({pipe_freeze, pc_write}), 32'(2'b01));
    tick();
    chk("dmem_stall", 32'(stall_cnt), 32'd4);
    chk("dmem_ret_state", 32'(state), 32'd0);

    // Halt: accept, drain, acknowledge; then resume
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      apply(1, 0, 0, 0, 0, 0, 1);
      chk("halt_ack", 32'(halt_ack), 32'(c >= 5));
      tick();
    end
    step(1, 0, 0, 0, 0, 0, 0);
    chk("halt_resume", 32'(state), 32'd0);

    // Halt with a two-cycle memory wait in the middle of the drain
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      apply(1, 0, 0, 0, 0, (c == 3 || c == 4), 1);
      chk("halt_ack_ext", 32'(halt_ack), 32'(c >= 7));
      tick();
    end
    step(1, 0, 0, 0, 0, 0, 0);

    // Memory wait timeout and its stickiness
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      apply(1, 0, 0, 0, 0, 1, 0);
      if (i == 256) chk("timeout_before", 32'(dmem_timeout), 32'd0);
      if (i == 257) chk("timeout_set", 32'(dmem_timeout), 32'd1);
      tick();
    end
    step(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    chk("timeout_sticky", 32'(dmem_timeout), 32'd1);
    chk("timeout_state", 32'(state), 32'd0);
    tick();

    // Reset arriving mid-drain discards everything, including the timeout
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("rst_drain_ack", 32'(halt_ack), 32'd0);
    tick();
    apply(1, 0, 0, 0, 0, 0, 0);
    chk("rst_drain_state", 32'(state), 32'd0);
    chk("rst_drain_stall", 32'(stall_cnt), 32'd0);
    chk("rst_drain_timeout", 32'(dmem_timeout), 32'd0);
    tick();

    // Random traffic against the model
    hr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hr = !hr;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           hr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, meaning max dmem wait cycles before timeout (1..255).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles to empty ID/EX, EX/MEM and MEM/WB.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 ld_use_haz  in  1  load-use hazard detected for the instruction in ID.
REQ-006 br_ctrl, br_taken  in  1 each  branch decoded in ID; register compare equal.
REQ-007 imem_busy, dmem_busy  in  1 each  instruction / data memory not ready this cycle.
REQ-008 halt_req  in  1  level request to drain and stop the pipeline.
REQ-009 pc_write, ifid_write  out  1 each  PC load enable; IF/ID load enable.
REQ-010 pc_sel_branch  out  1  PC loads the branch target instead of PC+4.
REQ-011 ifid_flush  out  1  IF/ID loads a NOP.
REQ-012 id_bubble  out  1  zero control bits into ID/EX.
REQ-013 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-014 halt_ack  out  1  pipeline empty and stopped.
REQ-015 dmem_timeout  out  1  sticky; set on wait-limit expiry.
REQ-016 state  out  2  current FSM state.
REQ-017 stall_cnt  out  16  saturating count of lost fetch cycles.

Function
REQ-018 SHALL implement states RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3.
REQ-019 Control outputs SHALL be combinational from state and inputs: zero-latency stall, matching decode-stage hazard timing.
REQ-020 RUN defaults: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-021 RUN priority, highest first: dmem_busy, ld_use_haz, taken branch (br_ctrl&br_taken), halt_req, imem_busy.
REQ-022 dmem_busy in RUN or DRAIN: pipe_freeze=1, pc_write=0, ifid_write=0, same cycle; next state MEM_WAIT; return state (RUN/DRAIN) saved.
REQ-023 MEM_WAIT: same outputs as REQ-022; 8-bit wait counter increments each cycle; dmem_busy=0 returns to saved state with outputs of that state in that cycle.
REQ-024 Wait counter reaching WAIT_LIMIT: dmem_timeout set, state unchanged, counter holds; cleared only by reset.
REQ-025 ld_use_haz: pc_write=0, ifid_write=0, id_bubble=1; state stays RUN.
REQ-026 Taken branch: pc_write=1, pc_sel_branch=1, ifid_flush=1.
REQ-027 halt_req accepted in RUN only if dmem_busy=0 and ld_use_haz=0. Acceptance cycle: ID instruction proceeds, ifid_flush=1. pc_write=pc_sel_branch=taken branch, else pc_write=0. Next state DRAIN.
REQ-028 imem_busy alone: pc_write=0, ifid_flush=1, ID proceeds.
REQ-029 DRAIN: pc_write=0, ifid_write=0, id_bubble=1. Drain counter advances only when not frozen. After DRAIN_CYCLES advancing cycles: HALTED.
REQ-030 HALTED: pc_write=0, ifid_write=0, id_bubble=1, halt_ack=1. Memory inputs ignored. halt_req=0 returns to RUN next cycle.
REQ-031 halt_req deassert during DRAIN SHALL NOT abort drain.
REQ-032 stall_cnt increments when state is RUN or MEM_WAIT and pc_write=0; saturates at 16'hFFFF.

Reset
REQ-033 reset_n=0 at an edge: state=RUN, wait/drain counters=0, saved state=RUN, stall_cnt=0, dmem_timeout=0.
REQ-034 While reset_n=0: pc_write=0, ifid_write=0, ifid_flush=1, id_bubble=1, all other outputs 0.
REQ-035 Reset mid-MEM_WAIT or mid-DRAIN SHALL discard all progress.

Structure
REQ-036 State encodings, DRAIN_CYCLES and WAIT_LIMIT defaults SHALL live in the shared pipeline package.
REQ-037 The saturating stall counter SHALL be a sub-module, sat_counter (parameterised width).
REQ-038 Outputs SHALL feed the fetch-stage PC/IF-ID enables and the decode-stage control-zero mux; they replace the standalone hazard unit's PCWrite/IFIDWrite.

Verification
REQ-039 ld_use_haz=1 for 1 cycle in RUN -> that cycle pc_write=0, ifid_write=0, id_bubble=1; stall_cnt=1; state stays 0.
REQ-040 br_ctrl=br_taken=1, imem_busy=1 -> pc_write=1, pc_sel_branch=1, ifid_flush=1.
REQ-041 dmem_busy=1 for 4 cycles from RUN -> pipe_freeze=1 for 4 cycles, state 1 for 3 cycles, then 0; stall_cnt=4.
REQ-042 halt_req=1 in RUN -> 1 accept cycle, DRAIN 3 cycles, halt_ack=1 in cycle 5; dmem_busy 2 cycles mid-DRAIN extends halt_ack to cycle 7.
REQ-043 dmem_busy held 300 cycles, WAIT_LIMIT=255 -> dmem_timeout set at wait count 255 and stays 1 after dmem_busy drops.
REQ-044 reset_n=0 during DRAIN -> next cycle state=0, halt_ack=0, stall_cnt=0, dmem_timeout=0.
